// File: rtl/baccarat_deal_ctrl_pkg.sv
// Shared types and helpers for the baccarat dealing controller.
// Optional build macro: AUTO_DEAL_EN adds the S_CLEAR state used for
// automatic re-dealing.
package baccarat_pkg;

  localparam int unsigned NATURAL_MIN_DEFAULT = 8;

  localparam logic [3:0] RANK_J = 4'd11;
  localparam logic [3:0] RANK_Q = 4'd12;
  localparam logic [3:0] RANK_K = 4'd13;

  typedef enum logic [3:0] {
    S_P1    = 4'd0,
    S_D1    = 4'd1,
    S_P2    = 4'd2,
    S_D2    = 4'd3,
    S_EVAL1 = 4'd4,
    S_P3    = 4'd5,
    S_EVAL2 = 4'd6,
    S_D3    = 4'd7,
    S_FINAL = 4'd8,
    S_DONE  = 4'd9
`ifdef AUTO_DEAL_EN
    ,
    S_CLEAR = 4'd10
`endif
  } state_t;

  // Baccarat point value of a rank: A..9 count face value, 10/J/Q/K and
  // invalid encodings count zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    logic [3:0] v;
    v = 4'd0;
    if ((rank >= 4'd1) && (rank <= 4'd9)) begin
      v = rank;
    end
    return v;
  endfunction

endpackage

// File: rtl/baccarat_deal_ctrl_if.sv
// Controller <-> card datapath signal bundle.
// Optional build macro: AUTO_DEAL_EN adds new_round / clear_hand.
interface baccarat_deal_ctrl_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
`ifdef AUTO_DEAL_EN
  logic       new_round;
  logic       clear_hand;
`endif

  // Controller side
  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
`ifdef AUTO_DEAL_EN
    ,
    input  new_round,
    output clear_hand
`endif
  );

  // Datapath / top-level side
  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
`ifdef AUTO_DEAL_EN
    ,
    output new_round,
    input  clear_hand
`endif
  );
endinterface

// File: rtl/baccarat_deal_ctrl_dealer_rule.sv
// Dealer third-card decision, applied after the player has drawn a third
// card. Purely combinational.
module baccarat_dealer_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3_val,
  output logic       draw
);

  // Draw table indexed by the dealer's two-card score and the player's
  // third-card value; scores of 7 and above (including out-of-range) stand.
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:    draw = (pcard3_val != 4'd8);
      4'd4:    draw = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
      4'd5:    draw = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
      4'd6:    draw = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
      default: draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat dealing sequencer: issues one-cycle card load strobes in dealing
// order, applies the natural and third-card rules to the datapath scores and
// registers the win lights once the hand is complete.
// Optional build macro: AUTO_DEAL_EN (new_round input, clear_hand output,
// S_CLEAR state for starting another hand without reset).
module baccarat_deal_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned NATURAL_MIN = NATURAL_MIN_DEFAULT
) (
  input logic                 slow_clock,
  input logic                 resetb,
  baccarat_deal_ctrl_if.master bus
);

  localparam logic [3:0] NAT_THR = 4'(NATURAL_MIN);

  state_t     state_q, state_d;
  logic       player_win_q, player_win_d;
  logic       dealer_win_q, dealer_win_d;
  logic       dealer_draw;
  logic [3:0] pcard3_val;
  logic [5:0] strobes;  // {p1, d1, p2, d2, p3, d3}
`ifdef AUTO_DEAL_EN
  logic       clear_hand;
`endif

  assign pcard3_val = card_value(bus.pcard3);

  baccarat_dealer_rule u_dealer_rule (
    .dscore     (bus.dscore),
    .pcard3_val (pcard3_val),
    .draw       (dealer_draw)
  );

  // State and win-light registers; reset returns to the first deal.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= S_P1;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
    end
  end

  // Next-state, light capture and Moore strobe decode.
  always_comb begin
    state_d      = state_q;
    player_win_d = player_win_q;
    dealer_win_d = dealer_win_q;
    strobes      = 6'b000000;
`ifdef AUTO_DEAL_EN
    clear_hand   = 1'b0;
`endif
    case (state_q)
      S_P1: begin
        strobes = 6'b100000;
        state_d = S_D1;
      end
      S_D1: begin
        strobes = 6'b010000;
        state_d = S_P2;
      end
      S_P2: begin
        strobes = 6'b001000;
        state_d = S_D2;
      end
      S_D2: begin
        strobes = 6'b000100;
        state_d = S_EVAL1;
      end
      S_EVAL1: begin
        if ((bus.pscore >= NAT_THR) || (bus.dscore >= NAT_THR)) begin
          state_d = S_FINAL;
        end else if (bus.pscore <= 4'd5) begin
          state_d = S_P3;
        end else if (bus.dscore <= 4'd5) begin
          state_d = S_D3;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_P3: begin
        strobes = 6'b000010;
        state_d = S_EVAL2;
      end
      S_EVAL2: begin
        state_d = dealer_draw ? S_D3 : S_FINAL;
      end
      S_D3: begin
        strobes = 6'b000001;
        state_d = S_FINAL;
      end
      S_FINAL: begin
        // Scores now include every loaded card; a tie lights both.
        state_d      = S_DONE;
        player_win_d = (bus.pscore >= bus.dscore);
        dealer_win_d = (bus.dscore >= bus.pscore);
      end
      S_DONE: begin
`ifdef AUTO_DEAL_EN
        if (bus.new_round) begin
          state_d      = S_CLEAR;
          player_win_d = 1'b0;
          dealer_win_d = 1'b0;
        end
`endif
      end
`ifdef AUTO_DEAL_EN
      S_CLEAR: begin
        clear_hand = 1'b1;
        state_d    = S_P1;
      end
`endif
      default: begin
        state_d = S_P1;
      end
    endcase
  end

  assign bus.load_pcard1      = strobes[5];
  assign bus.load_dcard1      = strobes[4];
  assign bus.load_pcard2      = strobes[3];
  assign bus.load_dcard2      = strobes[2];
  assign bus.load_pcard3      = strobes[1];
  assign bus.load_dcard3      = strobes[0];
  assign bus.player_win_light = player_win_q;
  assign bus.dealer_win_light = dealer_win_q;
`ifdef AUTO_DEAL_EN
  assign bus.clear_hand       = clear_hand;
`endif

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Directed bench for baccarat_deal_ctrl: the bench plays the datapath,
// queues the expected strobe/light trace for each hand and checks it cycle
// by cycle. Optional build macro: AUTO_DEAL_EN.
module tb_baccarat_deal_ctrl;

  localparam logic [3:0] NAT = 4'd8;

  typedef struct {
    logic [5:0] strb;   // {p1, d1, p2, d2, p3, d3}
    logic       pl;
    logic       dl;
  } exp_t;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  exp_t       q[$];
  logic [9:0] dtab [0:15];
  int         ntests = 0;
  int         nfail  = 0;

  baccarat_deal_ctrl_if bus ();

  baccarat_deal_ctrl #(.NATURAL_MIN(8)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic logic [5:0] obs_strb();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [5:0] s, input logic pl, input logic dl);
    exp_t e;
    e.strb = s;
    e.pl   = pl;
    e.dl   = dl;
    q.push_back(e);
  endtask

  // Play one hand from reset. p2/d2 are two-card scores, pf/df the scores
  // after any third cards. stop_after < 0 runs to completion plus two idle
  // cycles; otherwise only that many trace entries are checked.
  task automatic run_hand(input string tag, input logic [3:0] p2, input logic [3:0] d2,
                          input logic [3:0] rank, input logic [3:0] pf,
                          input logic [3:0] df, input int stop_after);
    logic       nat, pdraw, ddraw, plw, dlw;
    logic [3:0] v;
    exp_t       e;
    int         n;
    v     = ((rank >= 4'd1) && (rank <= 4'd9)) ? rank : 4'd0;
    nat   = (p2 >= NAT) || (d2 >= NAT);
    pdraw = !nat && (p2 <= 4'd5);
    ddraw = pdraw ? dtab[d2][v] : (!nat && (d2 <= 4'd5));
    plw   = (pf >= df);
    dlw   = (df >= pf);
    push(6'b100000, 1'b0, 1'b0);
    push(6'b010000, 1'b0, 1'b0);
    push(6'b001000, 1'b0, 1'b0);
    push(6'b000100, 1'b0, 1'b0);
    push(6'b000000, 1'b0, 1'b0);
    if (pdraw) begin
      push(6'b000010, 1'b0, 1'b0);
      push(6'b000000, 1'b0, 1'b0);
    end
    if (ddraw) push(6'b000001, 1'b0, 1'b0);
    push(6'b000000, 1'b0, 1'b0);
    push(6'b000000, plw, dlw);
    push(6'b000000, plw, dlw);
    push(6'b000000, plw, dlw);

    @(negedge slow_clock);
    bus.pscore = p2;
    bus.dscore = d2;
    bus.pcard3 = rank;
    resetb     = 1'b0;
    #1;
    n = 0;
    while ((q.size() > 0) && ((stop_after < 0) || (n < stop_after))) begin
      if (n > 0) begin
        @(posedge slow_clock);
        @(negedge slow_clock);
      end
      e = q.pop_front();
      chk({tag, "/strb"}, {2'b00, obs_strb()}, {2'b00, e.strb});
      chk({tag, "/lights"}, {6'd0, bus.player_win_light, bus.dealer_win_light},
          {6'd0, e.pl, e.dl});
      if (n == 0) resetb = 1'b1;
      if (bus.load_pcard3) bus.pscore = pf;
      if (bus.load_dcard3) bus.dscore = df;
      n++;
    end
    q.delete();
  endtask

  initial begin
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd0;
`ifdef AUTO_DEAL_EN
    bus.new_round = 1'b0;
`endif
    dtab[0] = 10'h3FF; dtab[1] = 10'h3FF; dtab[2] = 10'h3FF;
    dtab[3] = 10'h2FF; dtab[4] = 10'h0FC; dtab[5] = 10'h0F0;
    dtab[6] = 10'h0C0;
    for (int i = 7; i < 16; i++) dtab[i] = 10'h000;

    repeat (2) @(posedge slow_clock);

    // Naturals, including dealer natural and an out-of-range score.
    run_hand("natural", 4'd8, 4'd3, 4'd5, 4'd8, 4'd3, -1);
    run_hand("dnat9", 4'd7, 4'd9, 4'd5, 4'd7, 4'd9, -1);
    run_hand("score10", 4'd10, 4'd3, 4'd5, 4'd10, 4'd3, -1);

    // Player draws, dealer stands on 7.
    run_hand("pdraw", 4'd4, 4'd7, 4'd5, 4'd9, 4'd7, -1);
    // Player stands on 6, dealer draws from 2, tie at 6.
    run_hand("tie", 4'd6, 4'd2, 4'd0, 4'd6, 4'd6, -1);
    // Player 7 / dealer 6: both stand.
    run_hand("bothstand", 4'd7, 4'd6, 4'd3, 4'd7, 4'd6, -1);
    // Both draw: player 2+9 -> 1, dealer ends on 5.
    run_hand("bothdraw", 4'd2, 4'd1, 4'd9, 4'd1, 4'd5, -1);

    // Dealer rule sweep over dscore 3..6 and every rank encoding.
    for (int d = 3; d <= 6; d++) begin
      for (int r = 0; r < 16; r++) begin
        run_hand($sformatf("rule_d%0d_r%0d", d, r), 4'd3, 4'(d), 4'(r), 4'd3, 4'(d), -1);
      end
    end

    // Reset after a complete hand clears the lights immediately.
    run_hand("prerst", 4'd9, 4'd0, 4'd1, 4'd9, 4'd0, -1);
    @(negedge slow_clock);
    resetb = 1'b0;
    #1;
    chk("rst_lights", {6'd0, bus.player_win_light, bus.dealer_win_light}, 8'h00);
    chk("rst_strb", {2'b00, obs_strb()}, 8'h20);

    // Mid-hand reset while in S_P3: load_pcard3 drops the same cycle.
    run_hand("midrst", 4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 6);
    chk("midrst_in_p3", {7'd0, bus.load_pcard3}, 8'h01);
    resetb = 1'b0;
    #1;
    chk("midrst_p3_low", {7'd0, bus.load_pcard3}, 8'h00);
    chk("midrst_strb", {2'b00, obs_strb()}, 8'h20);
    resetb = 1'b1;

`ifdef AUTO_DEAL_EN
    run_hand("auto", 4'd5, 4'd7, 4'd8, 4'd3, 4'd7, -1);
    bus.new_round = 1'b1;
    @(posedge slow_clock);
    @(negedge slow_clock);
    bus.new_round = 1'b0;
    chk("auto_clear", {7'd0, bus.clear_hand}, 8'h01);
    chk("auto_clear_lights", {6'd0, bus.player_win_light, bus.dealer_win_light}, 8'h00);
    chk("auto_clear_strb", {2'b00, obs_strb()}, 8'h00);
    @(posedge slow_clock);
    @(negedge slow_clock);
    chk("auto_clear_off", {7'd0, bus.clear_hand}, 8'h00);
    chk("auto_p1", {2'b00, obs_strb()}, 8'h20);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/baccarat_deal_ctrl.md
Name: baccarat_deal_ctrl

Overview:
Sequencing controller for the baccarat card datapath: player/dealer card registers, scorers and card7seg displays. It issues one-cycle load strobes in the dealing order and applies the natural and third-card rules to the scores the datapath returns. It registers the win lights when the hand is complete. It sits between the top level (slow_clock derived from a debounced key) and the datapath.

Parameters:
NATURAL_MIN, 8, score at or above which a two-card hand is a natural and ends the hand.

Ports:
slow_clock  in  1  sole clock; all state changes on its rising edge
resetb  in  1  asynchronous, active-low reset
pscore  in  4  player hand score 0..9, combinational from loaded cards
dscore  in  4  dealer hand score 0..9, combinational from loaded cards
pcard3  in  4  player third-card rank: 1=A, 2..10, 11=J, 12=Q, 13=K; 0/14/15 invalid
load_pcard1, load_pcard2, load_pcard3  out  1 each  player card register load strobes
load_dcard1, load_dcard2, load_dcard3  out  1 each  dealer card register load strobes
player_win_light  out  1  registered player win / tie indicator
dealer_win_light  out  1  registered dealer win / tie indicator

Behaviour:
- resetb=0 (asynchronous): state=S_P1; both lights=0. Load strobes are Moore outputs, so only load_pcard1 is high while in S_P1.
- States: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_FINAL, S_DONE.
- Load states S_P1/S_D1/S_P2/S_D2/S_P3/S_D3 each assert exactly their own strobe for exactly one cycle. All strobes are 0 in every other state. At most one strobe is high at any time.
- Fixed order: S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_EVAL1.
- S_EVAL1 (two-card scores valid):
  - pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> S_FINAL.
  - else pscore<=5 -> S_P3.
  - else (pscore 6/7): dscore<=5 -> S_D3; otherwise -> S_FINAL.
- S_P3 -> S_EVAL2.
- S_EVAL2: v = card value of pcard3 (rank 1..9 -> rank; 10..13 and invalid -> 0). Dealer draws (-> S_D3) when:
  - dscore 0..2: always.
  - dscore 3: v!=8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7..9: never.
  Otherwise -> S_FINAL.
- S_D3 -> S_FINAL. S_FINAL exists so the datapath score reflects the last load.
- S_FINAL -> S_DONE. On that edge, capture the lights:
  - player_win_light = pscore>=dscore.
  - dealer_win_light = dscore>=pscore.
  - A tie lights both.
- S_DONE: absorbing (unless the optional feature is enabled). Lights hold; no strobes.
- Edges from reset release to lights valid:
  - natural: 6
  - player stands, dealer draws: 7
  - player draws, dealer stands: 8
  - both draw: 9
- Scores above 9 are treated as is in comparisons; no saturation.
- resetb asserted mid-hand: immediate return to S_P1 with lights cleared. The strobe is cut combinationally the same cycle.

Optional Feature:
AUTO_DEAL_EN.
- Defined: adds input new_round (1b) and output clear_hand (1b), plus state S_CLEAR.
  - In S_DONE, new_round=1 at an edge -> S_CLEAR and both lights cleared.
  - S_CLEAR asserts clear_hand for one cycle (datapath zeroes all card registers), then -> S_P1.
  - new_round is ignored in every other state.
- Undefined: the ports and S_CLEAR do not exist; S_DONE exits only via resetb.

Decomposition:
- Package baccarat_pkg holds:
  - state_t enum
  - NATURAL_MIN default constant
  - card_value function (rank -> 0..9)
  - rank constants RANK_J/Q/K
- One natural sub-module: baccarat_dealer_rule, a purely combinational function of (dscore, pcard3 value) giving the draw decision. It is instantiated in S_EVAL2 decode and unit-testable alone.

Test Plan:
- Reset: resetb=0 -> state S_P1, only load_pcard1=1, lights 0; release -> strobes P1,D1,P2,D2 on successive edges, one-hot.
- Natural: pscore=8, dscore=3 at S_EVAL1 -> no P3/D3 strobes; after edge 6 player_win_light=1, dealer_win_light=0.
- Player draws, dealer stands: pscore=4, dscore=7; then pcard3=5 (v=5) -> load_pcard3 only; with final pscore=9 -> player light only after edge 8.
- Dealer rule sweep: dscore 3..6 against pcard3 ranks 1..13 -> S_D3 iff the table holds (e.g. dscore=3, pcard3=8 -> stand; dscore=6, pcard3=12 -> stand; dscore=4, pcard3=2 -> draw).
- Tie and banker-only draw: pscore=6, dscore=2 -> load_dcard3 directly after S_EVAL1; final both 6 -> both lights=1 after edge 7.
- Mid-hand reset at S_P3 -> load_pcard3 drops same cycle, state S_P1; under AUTO_DEAL_EN, new_round in S_DONE -> clear_hand pulse 1 cycle, then load_pcard1.
